mask_regfile_mp: RTL and testbench

//  Multi-read-port mask register file for the vector unit: 32 mask registers, each VLEN_B bits, held as DATA_WIDTH-bit packets.

---
 rtl/mask_regfile_mp_if.sv | 33 +++
 rtl/mask_regfile_mp.sv | 145 ++++++++++++++
 tb/tb_mask_regfile_mp.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mask_regfile_mp_if.sv
// Bus bundle for the multi-read-port mask register file: clear request/busy,
// one bit-masked write port and NRD packed read ports.
interface mask_regfile_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int OFF_BITS   = 8,
  parameter int NRD        = 3
);
  logic                     clr_req;
  logic                     busy;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [OFF_BITS-1:0]      wr_off;
  logic [DATA_WIDTH-1:0]    wr_bmask;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [NRD-1:0]           rd_en;
  logic [NRD*ADDR_WIDTH-1:0] rd_addr;
  logic [NRD*OFF_BITS-1:0]  rd_off;
  logic [NRD*DATA_WIDTH-1:0] rd_data;
  logic [NRD-1:0]           rd_valid;

  modport master (
    output clr_req, wr_en, wr_addr, wr_off, wr_bmask, wr_data,
           rd_en, rd_addr, rd_off,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_off, wr_bmask, wr_data,
           rd_en, rd_addr, rd_off,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/mask_regfile_mp.sv
// Multi-read-port mask register file for the vector unit.
// 32 mask registers of VLEN/8 bits, stored as DATA_WIDTH-bit packets.
// Bit-granular writes, NRD independent 1-cycle read ports, and a clear
// sequencer that zeroes the whole array after reset or on clr_req.
// Optional feature macro: MASK_RF_BYPASS_EN (forward same-cycle write data
// to a colliding read; undefined = reads see pre-write contents).
//
// state | meaning
// CLEAR | zeroing entry clr_cnt each cycle, busy=1, ports ignored
// IDLE  | normal read/write service, busy=0
module mask_regfile_mp #(
  parameter int VLEN       = 16384,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int OFF_BITS   = 8,
  parameter int NRD        = 3
) (
  input logic clk,
  input logic rst,
  mask_regfile_mp_if.slave bus
);
  localparam int VLEN_B       = VLEN >> 3;
  localparam int PACK_PER_REG = VLEN_B / DATA_WIDTH;
  localparam int DEPTH        = PACK_PER_REG << ADDR_WIDTH;
  localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // When the offset field cannot even encode PACK_PER_REG, every offset is legal.
  localparam bit OFF_ALL_IN   = (PACK_PER_REG >= (1 << OFF_BITS));
  localparam logic [OFF_BITS-1:0] PPR_OFF  = OFF_BITS'(PACK_PER_REG);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  busy;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in;
  logic                  wr_fire;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_merged;

  logic [DATA_WIDTH-1:0] rd_val [NRD];
  logic [NRD*DATA_WIDTH-1:0] rd_data_q;
  logic [NRD-1:0]        rd_valid_q;

  function automatic logic off_in_range(input logic [OFF_BITS-1:0] off);
    return OFF_ALL_IN || (off < PPR_OFF);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [OFF_BITS-1:0] off);
    return IDX_W'(a) * IDX_W'(PACK_PER_REG) + IDX_W'(off);
  endfunction

  // State register; reset always restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state: walk every entry once, then serve; clr_req only honoured in IDLE.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        clr_cnt_d = '0;
        if (bus.clr_req) state_d = CLEAR;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign bus.busy = busy;

  // Write decode and bit-merge of new data into the current entry.
  always_comb begin
    wr_in     = off_in_range(bus.wr_off);
    wr_idx    = to_idx(bus.wr_addr, bus.wr_off);
    wr_fire   = bus.wr_en & ~busy & wr_in;
    wr_merged = (mem[wr_idx] & ~bus.wr_bmask) | (bus.wr_data & bus.wr_bmask);
  end

  // Storage: clear sequencer owns the array while busy; no reset on the array.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  // Per-port read lookup; out-of-range offsets read as zero.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      logic [ADDR_WIDTH-1:0] a;
      logic [OFF_BITS-1:0]   o;
      logic [IDX_W-1:0]      idx;
      logic                  in_r;
      a    = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      o    = bus.rd_off[p*OFF_BITS +: OFF_BITS];
      idx  = to_idx(a, o);
      in_r = off_in_range(o);
      rd_val[p] = in_r ? mem[idx] : '0;
`ifdef MASK_RF_BYPASS_EN
      if (in_r && wr_fire && (idx == wr_idx)) rd_val[p] = wr_merged;
`endif
    end
  end

  // Read pipeline register; data holds when a port is not strobed.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      if (rst) begin
        rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
        rd_valid_q[p]                         <= 1'b0;
      end else begin
        rd_valid_q[p] <= bus.rd_en[p] & ~busy;
        if (bus.rd_en[p] & ~busy) rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_val[p];
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_mask_regfile_mp.sv
// Directed bench for mask_regfile_mp at VLEN=1024 (2 packets/reg, 64 entries).
module tb_mask_regfile_mp;
  localparam int VLEN = 1024;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int OB   = 8;
  localparam int NRD  = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mask_regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFF_BITS(OB), .NRD(NRD)) bus ();

  mask_regfile_mp #(.VLEN(VLEN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFF_BITS(OB), .NRD(NRD))
    dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic idle_inputs();
    bus.clr_req  = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_off   = '0;
    bus.wr_bmask = '0;
    bus.wr_data  = '0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.rd_off   = '0;
  endtask

  // Called at a negedge; returns at the next negedge after the write is taken.
  task automatic write_pkt(input logic [AW-1:0] a, input logic [OB-1:0] o,
                           input logic [DW-1:0] m, input logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_off = o; bus.wr_bmask = m; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the read result is visible.
  task automatic issue_read(input logic [NRD-1:0] en, input logic [NRD*AW-1:0] a,
                            input logic [NRD*OB-1:0] o);
    bus.rd_en = en; bus.rd_addr = a; bus.rd_off = o;
    @(negedge clk);
    bus.rd_en = '0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b exp 1", bus.busy); end
    n_tests++;
    if (bus.rd_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b exp 000", bus.rd_valid); end
    n_tests++;
    if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", bus.rd_data); end
    rst = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    n_tests++;
    if (cnt != 64) begin n_fail++; $display("FAIL reset_clear_len: got %0d exp 64", cnt); end
    for (int r = 0; r < 32; r++) begin
      for (int o = 0; o < 2; o++) begin
        issue_read(3'b111, {3{AW'(r)}}, {3{OB'(o)}});
        n_tests++;
        if (bus.rd_valid !== 3'b111 || bus.rd_data !== '0) begin
          n_fail++;
          $display("FAIL init_read r%0d o%0d: valid %b data %h exp 111/0", r, o, bus.rd_valid, bus.rd_data);
        end
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.rd_valid !== 3'b000) begin n_fail++; $display("FAIL no_rd_en_valid: got %b exp 000", bus.rd_valid); end
  endtask

  task automatic test_bitmask();
    write_pkt(5'd5, 8'd1, {DW{1'b1}}, 64'hFFFF_0000_FFFF_0000);
    write_pkt(5'd5, 8'd1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_1234);
    issue_read(3'b001, {5'd0, 5'd0, 5'd5}, {8'd0, 8'd0, 8'd1});
    n_tests++;
    if (bus.rd_valid !== 3'b001 || bus.rd_data[0 +: DW] !== 64'hFFFF_0000_FFFF_1234) begin
      n_fail++;
      $display("FAIL bitmask_merge: valid %b data %h exp 001/ffff0000ffff1234", bus.rd_valid, bus.rd_data[0 +: DW]);
    end
    @(negedge clk);
    n_tests++;
    if (bus.rd_valid !== 3'b000 || bus.rd_data[0 +: DW] !== 64'hFFFF_0000_FFFF_1234) begin
      n_fail++;
      $display("FAIL rd_hold: valid %b data %h exp 000/ffff0000ffff1234", bus.rd_valid, bus.rd_data[0 +: DW]);
    end
  endtask

  task automatic test_multiport();
    issue_read(3'b111, {5'd0, 5'd5, 5'd5}, {8'd0, 8'd1, 8'd1});
    n_tests++;
    if (bus.rd_valid !== 3'b111 || bus.rd_data[0 +: DW] !== 64'hFFFF_0000_FFFF_1234 ||
        bus.rd_data[DW +: DW] !== 64'hFFFF_0000_FFFF_1234 || bus.rd_data[2*DW +: DW] !== 64'h0) begin
      n_fail++;
      $display("FAIL multiport_same: valid %b data %h", bus.rd_valid, bus.rd_data);
    end
    write_pkt(5'd31, 8'd1, {DW{1'b1}}, 64'h0123_4567_89AB_CDEF);
    issue_read(3'b101, {5'd5, 5'd0, 5'd31}, {8'd1, 8'd0, 8'd1});
    n_tests++;
    if (bus.rd_valid !== 3'b101 || bus.rd_data[0 +: DW] !== 64'h0123_4567_89AB_CDEF ||
        bus.rd_data[DW +: DW] !== 64'hFFFF_0000_FFFF_1234 ||
        bus.rd_data[2*DW +: DW] !== 64'hFFFF_0000_FFFF_1234) begin
      n_fail++;
      $display("FAIL multiport_mixed: valid %b data %h", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_col;
`ifdef MASK_RF_BYPASS_EN
    exp_col = 64'hAA;
`else
    exp_col = 64'h0;
`endif
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_off = 8'd0; bus.wr_bmask = {DW{1'b1}}; bus.wr_data = 64'hAA;
    bus.rd_en = 3'b001; bus.rd_addr = {5'd0, 5'd0, 5'd3}; bus.rd_off = '0;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = '0;
    n_tests++;
    if (bus.rd_valid[0] !== 1'b1 || bus.rd_data[0 +: DW] !== exp_col) begin
      n_fail++;
      $display("FAIL collision: valid %b data %h exp 1/%h", bus.rd_valid[0], bus.rd_data[0 +: DW], exp_col);
    end
    issue_read(3'b010, {5'd0, 5'd3, 5'd0}, {8'd0, 8'd0, 8'd0});
    n_tests++;
    if (bus.rd_valid !== 3'b010 || bus.rd_data[DW +: DW] !== 64'hAA) begin
      n_fail++;
      $display("FAIL after_collision: valid %b data %h exp 010/aa", bus.rd_valid, bus.rd_data[DW +: DW]);
    end
  endtask

  task automatic test_out_of_range();
    write_pkt(5'd7, 8'd0, {DW{1'b1}}, 64'h7070);
    write_pkt(5'd7, 8'd1, {DW{1'b1}}, 64'h7171);
    write_pkt(5'd7, 8'd2, {DW{1'b1}}, 64'hDEAD);
    issue_read(3'b111, {5'd7, 5'd7, 5'd7}, {8'd2, 8'd1, 8'd0});
    n_tests++;
    if (bus.rd_valid !== 3'b111 || bus.rd_data[0 +: DW] !== 64'h7070 ||
        bus.rd_data[DW +: DW] !== 64'h7171 || bus.rd_data[2*DW +: DW] !== 64'h0) begin
      n_fail++;
      $display("FAIL oor_write_read: valid %b data %h", bus.rd_valid, bus.rd_data);
    end
    issue_read(3'b001, {5'd0, 5'd0, 5'd8}, {8'd0, 8'd0, 8'd0});
    n_tests++;
    if (bus.rd_valid !== 3'b001 || bus.rd_data[0 +: DW] !== 64'h0) begin
      n_fail++;
      $display("FAIL oor_alias: valid %b data %h exp 001/0", bus.rd_valid, bus.rd_data[0 +: DW]);
    end
  endtask

  task automatic test_clear();
    int cnt;
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    cnt = 0;
    // Exercise ignored inputs while the clear runs.
    while (bus.busy === 1'b1 && cnt < 200) begin
      if (cnt >= 6 && cnt <= 8) begin
        n_tests++;
        if (bus.rd_valid !== 3'b000) begin n_fail++; $display("FAIL busy_rd_valid c%0d: got %b exp 000", cnt, bus.rd_valid); end
      end
      bus.rd_en = (cnt >= 5 && cnt < 8) ? 3'b111 : 3'b000;
      bus.rd_addr = {3{5'd5}}; bus.rd_off = {3{8'd1}};
      bus.clr_req = (cnt == 10);
      bus.wr_en = (cnt == 40); bus.wr_addr = 5'd9; bus.wr_off = 8'd0;
      bus.wr_bmask = {DW{1'b1}}; bus.wr_data = 64'hBEEF;
      cnt++;
      @(negedge clk);
    end
    idle_inputs();
    n_tests++;
    if (cnt != 64) begin n_fail++; $display("FAIL clear_len: got %0d exp 64", cnt); end
    issue_read(3'b011, {5'd0, 5'd9, 5'd5}, {8'd0, 8'd0, 8'd1});
    n_tests++;
    if (bus.rd_valid !== 3'b011 || bus.rd_data[0 +: DW] !== 64'h0 || bus.rd_data[DW +: DW] !== 64'h0) begin
      n_fail++;
      $display("FAIL after_clear: valid %b data %h exp 011/0,0", bus.rd_valid, bus.rd_data);
    end
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    n_tests++;
    if (cnt != 64) begin n_fail++; $display("FAIL reset_mid_clear_len: got %0d exp 64", cnt); end
    write_pkt(5'd2, 8'd1, 64'h0000_0000_FFFF_FFFF, 64'h5555_5555_5555_5555);
    issue_read(3'b100, {5'd2, 5'd0, 5'd0}, {8'd1, 8'd0, 8'd0});
    n_tests++;
    if (bus.rd_valid !== 3'b100 || bus.rd_data[2*DW +: DW] !== 64'h0000_0000_5555_5555) begin
      n_fail++;
      $display("FAIL post_reset_write: valid %b data %h exp 100/0000000055555555", bus.rd_valid, bus.rd_data[2*DW +: DW]);
    end
  endtask

  initial begin
    test_reset();
    test_bitmask();
    test_multiport();
    test_collision();
    test_out_of_range();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
